// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
//   Initiator side of the CSR register-file port. Executes the Zicsr
//   instructions (CSRRW/S/C and CSRRWI/SI/CI) as a sequenced read-modify-write
//   on the CSR register file and returns the old CSR value for rd.
//
//   Optional feature macro: CSR_ADDR_CHECK_EN
//     defined   : only 0x300,0x301,0x304,0x305,0x340,0x341,0x342,0x344 are
//                 legal; any other address is flagged illegal with no access.
//     undefined : every address is forwarded to the register file.
//
// Parameters
//   READ_LATENCY        cycles from csr_read_enable_o to valid csr_read_data_i (1..7)
//
// Ports
//   clk_i               in   clock, all logic on posedge
//   rst_i               in   synchronous active-high reset
//   req_valid_i         in   operation request valid
//   req_ready_o         out  unit can accept a request (IDLE only)
//   funct3_i[2:0]       in   Zicsr funct3
//   csr_addr_i[11:0]    in   target CSR address
//   rs1_data_i[31:0]    in   rs1 value (register forms)
//   uimm_i[4:0]         in   zimm field (immediate forms)
//   rd_is_zero_i        in   rd == x0
//   rs1_is_zero_i       in   rs1 field == 0
//   rsp_valid_o         out  response valid, held until rsp_ready_i
//   rsp_ready_i         in   consumer accepts response
//   rsp_rd_data_o[31:0] out  old CSR value (0 if the read was skipped)
//   rsp_illegal_o       out  illegal-instruction flag
//   csr_read_enable_o   out  register-file read strobe
//   csr_write_enable_o  out  register-file write strobe
//   csr_address_o[11:0] out  register-file address, stable READ..WRITE
//   csr_write_data_o    out  register-file write data
//   csr_read_data_i     in   register-file read data
// -----------------------------------------------------------------------------
module csr_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  uimm_i,
    input  logic        rd_is_zero_i,
    input  logic        rs1_is_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rd_data_o,
    output logic        rsp_illegal_o,
    output logic        csr_read_enable_o,
    output logic        csr_write_enable_o,
    output logic [11:0] csr_address_o,
    output logic [31:0] csr_write_data_o,
    input  logic [31:0] csr_read_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_src;
    logic        r_do_read;
    logic        r_do_write;
    logic        r_illegal;
    logic [31:0] r_old;
    logic [2:0]  r_wait_cnt;

    logic        w_accept;
    logic [31:0] w_src;
    logic        w_src_zero;
    logic        w_do_read;
    logic        w_do_write;
    logic        w_addr_ok;
    logic        w_illegal;
    logic        w_wait_last;
    logic [31:0] w_wdata;

    // ---------------------------------------------------------------- decode
    assign w_accept   = req_valid_i && (r_state == S_IDLE);
    assign w_src      = funct3_i[2] ? {27'b0, uimm_i} : rs1_data_i;
    assign w_src_zero = funct3_i[2] ? (uimm_i == 5'd0) : rs1_is_zero_i;
    // RW/RWI with rd=x0 must not read: reads can have side effects.
    assign w_do_read  = !((funct3_i[1:0] == 2'b01) && rd_is_zero_i);
    // Set/clear with a zero source is a pure read.
    assign w_do_write = (funct3_i[1:0] == 2'b01) || !w_src_zero;

`ifdef CSR_ADDR_CHECK_EN
    always_comb begin
        w_addr_ok = 1'b0;
        case (csr_addr_i)
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h344: w_addr_ok = 1'b1;
            default:                            w_addr_ok = 1'b0;
        endcase
    end
`else
    assign w_addr_ok = 1'b1;
`endif

    // addr[11:10]==11 is the read-only CSR space.
    assign w_illegal = (funct3_i[1:0] == 2'b00)
                    || (w_do_write && (csr_addr_i[11:10] == 2'b11))
                    || !w_addr_ok;

    assign w_wait_last = (r_wait_cnt == 3'(READ_LATENCY - 1));

    // old value is 0 when the read was skipped (r_old cleared on accept)
    always_comb begin
        w_wdata = r_src;
        case (r_op)
            2'b10:   w_wdata = r_old | r_src;
            2'b11:   w_wdata = r_old & ~r_src;
            default: w_wdata = r_src;
        endcase
    end

    // ------------------------------------------------------------ state reg
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_addr     <= 12'h000;
            r_src      <= 32'h0;
            r_do_read  <= 1'b0;
            r_do_write <= 1'b0;
            r_illegal  <= 1'b0;
            r_old      <= 32'h0;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= funct3_i[1:0];
                r_addr     <= csr_addr_i;
                r_src      <= w_src;
                r_do_read  <= w_do_read;
                r_do_write <= w_do_write;
                r_illegal  <= w_illegal;
                r_old      <= 32'h0;
            end
            if (r_state == S_READ) begin
                r_wait_cnt <= 3'd0;
            end
            if (r_state == S_WAIT) begin
                if (w_wait_last) begin
                    r_old <= csr_read_data_i;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: begin
                if (r_illegal)      w_next = S_RESP;
                else if (r_do_read) w_next = S_READ;
                else                w_next = S_WRITE;
            end
            S_READ:   w_next = S_WAIT;
            S_WAIT:   if (w_wait_last) w_next = r_do_write ? S_WRITE : S_RESP;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   if (rsp_ready_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    // Strobes are masked by rst_i so an op caught by reset never issues its
    // access in the reset cycle itself.
    always_comb begin
        req_ready_o        = (r_state == S_IDLE);
        csr_read_enable_o  = 1'b0;
        csr_write_enable_o = 1'b0;
        csr_address_o      = 12'h000;
        csr_write_data_o   = 32'h0;
        rsp_valid_o        = 1'b0;
        rsp_rd_data_o      = 32'h0;
        rsp_illegal_o      = 1'b0;
        case (r_state)
            S_READ: begin
                csr_read_enable_o = !rst_i;
                csr_address_o     = r_addr;
            end
            S_WAIT: begin
                csr_address_o = r_addr;
            end
            S_WRITE: begin
                csr_write_enable_o = !rst_i;
                csr_address_o      = r_addr;
                csr_write_data_o   = w_wdata;
            end
            S_RESP: begin
                rsp_valid_o   = !rst_i;
                rsp_rd_data_o = r_old;
                rsp_illegal_o = r_illegal;
            end
            default: ;
        endcase
    end

endmodule
